// File: rtl/booth_radix4_seq.sv
// Iterative radix-4 Booth multiplier with a single-issue valid/ready handshake.
// Optional early termination is compiled in when BOOTH_EARLY_TERM_EN is defined.
module booth_radix4_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned G  = WIDTH / 2 + 1;
  localparam int unsigned GW = $clog2(G + 1);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned MW = WIDTH + 3;

  localparam logic [MW-1:0] m_one   = {{(MW - 1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] grp_one = {{(GW - 1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] grp_last = GW'(G - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH+1:0]  xe_q, xe_d;
  logic [WIDTH+2:0]  breg_q, breg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [PW-1:0]     product_q, product_d;

  logic [MW-1:0]     x1, x2, mult;
  logic [PW-1:0]     mult_ext, acc_sum;
  logic [GW:0]       shamt;
  logic [WIDTH+2:0]  breg_sh;
  logic              grp_done;

  always_comb begin
    x1 = {xe_q[WIDTH+1], xe_q};
    x2 = {xe_q, 1'b0};
    unique case (breg_q[2:0])
      3'b001, 3'b010: mult = x1;
      3'b011:         mult = x2;
      3'b100:         mult = ~x2 + m_one;
      3'b101, 3'b110: mult = ~x1 + m_one;
      default:        mult = '0;
    endcase
    mult_ext = {{(PW - MW){mult[MW-1]}}, mult};
    shamt    = {grp_q, 1'b0};
    acc_sum  = acc_q + (mult_ext << shamt);
    breg_sh  = {breg_q[WIDTH+2], breg_q[WIDTH+2], breg_q[WIDTH+2:2]};
`ifdef BOOTH_EARLY_TERM_EN
    // Arithmetic shift replicates the top bit, so a uniform register means only 000/111 remain.
    grp_done = (grp_q == grp_last) || (&breg_sh) || ~(|breg_sh);
`else
    grp_done = (grp_q == grp_last);
`endif
  end

  always_comb begin
    state_d   = state_q;
    xe_d      = xe_q;
    breg_d    = breg_q;
    acc_d     = acc_q;
    grp_d     = grp_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          xe_d    = in_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
          breg_d  = {(in_signed ? {2{b[WIDTH-1]}} : 2'b00), b, 1'b0};
          acc_d   = '0;
          grp_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d  = acc_sum;
        breg_d = breg_sh;
        grp_d  = grp_q + grp_one;
        if (grp_done) begin
          product_d = acc_sum;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      xe_q      <= '0;
      breg_q    <= '0;
      acc_q     <= '0;
      grp_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      xe_q      <= xe_d;
      breg_q    <= breg_d;
      acc_q     <= acc_d;
      grp_q     <= grp_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign product   = product_q;

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Self-checking bench for booth_radix4_seq: directed vectors, handshake, reset and random checks
// against an arithmetic reference model. Honors BOOTH_EARLY_TERM_EN for latency expectations.
module tb_booth_radix4_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int checks = 0;
  int passes = 0;

  booth_radix4_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                           input logic s);
    logic [63:0] xx, yy;
    xx = s ? {{32{x[31]}}, x} : {32'b0, x};
    yy = s ? {{32{y[31]}}, y} : {32'b0, y};
    return xx * yy;
  endfunction

  // Cycles from accept to out_valid: 17 fixed, or the first k where the multiplier bits
  // left after k two-bit steps are all-zero or all-one.
  function automatic int ref_lat(input logic [31:0] y, input logic s);
`ifdef BOOTH_EARLY_TERM_EN
    longint r;
    r = s ? longint'($signed(y)) : longint'({32'b0, y});
    r = r * 2;
    for (int k = 1; k <= 17; k++) begin
      if ((r >>> (2 * k)) == 0 || (r >>> (2 * k)) == -1) return k;
    end
    return 17;
`else
    return 17;
`endif
  endfunction

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                       output logic [63:0] p, output int lat);
    @(negedge clk);
    a = x; b = y; in_signed = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    p = product;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else passes++;
    checks++; if (product !== 64'h0) $display("FAIL reset_product got %h want 0", product);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta[5], tbv[5];
    logic        ts[5];
    logic [63:0] tp[5];
    logic [63:0] p;
    int          lat;
    ta[0] = 32'hFFFFFFFD; tbv[0] = 32'd7;        ts[0] = 1; tp[0] = 64'hFFFFFFFF_FFFFFFEB;
    ta[1] = 32'hFFFFFFFF; tbv[1] = 32'hFFFFFFFF; ts[1] = 0; tp[1] = 64'hFFFFFFFE_00000001;
    ta[2] = 32'hFFFFFFFF; tbv[2] = 32'hFFFFFFFF; ts[2] = 1; tp[2] = 64'h00000000_00000001;
    ta[3] = 32'h80000000; tbv[3] = 32'h80000000; ts[3] = 1; tp[3] = 64'h40000000_00000000;
    ta[4] = 32'h80000000; tbv[4] = 32'h7FFFFFFF; ts[4] = 1; tp[4] = 64'hC0000000_80000000;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tbv[i], ts[i], p, lat);
      checks++;
      if (p !== tp[i]) $display("FAIL directed_%0d_product got %h want %h", i, p, tp[i]);
      else passes++;
      checks++;
      if (lat != ref_lat(tbv[i], ts[i]))
        $display("FAIL directed_%0d_latency got %0d want %0d", i, lat, ref_lat(tbv[i], ts[i]));
      else passes++;
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] p, exp;
    int          lat;
    exp = ref_prod(32'd1234, -32'sd56, 1'b1);
    do_op(32'd1234, -32'sd56, 1'b1, p, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 32'd9; b = 32'd9; in_valid = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0)
        $display("FAIL hold_%0d got v=%b p=%h r=%b want v=1 p=%h r=0",
                 i, out_valid, product, in_ready, exp);
      else passes++;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL handoff got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    else passes++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (product !== exp || busy !== 1'b0)
      $display("FAIL product_retained got p=%h busy=%b want p=%h busy=0", product, busy, exp);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] p;
    int          lat;
    @(negedge clk);
    a = 32'd100; b = 32'h5A5A5A5A; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || product !== 64'h0)
      $display("FAIL reset_mid got v=%b busy=%b r=%b p=%h want 0 0 1 0",
               out_valid, busy, in_ready, product);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    do_op(32'd6, 32'hFFFFFFFE, 1'b1, p, lat);
    checks++;
    if (p !== 64'hFFFFFFFF_FFFFFFF4)
      $display("FAIL after_reset_product got %h want fffffffffffffff4", p);
    else passes++;
    release_out();
  endtask

  task automatic test_early_term();
    logic [63:0] p;
    int          lat, exp5, exp0;
`ifdef BOOTH_EARLY_TERM_EN
    exp5 = 2; exp0 = 1;
`else
    exp5 = 17; exp0 = 17;
`endif
    do_op(32'd5, 32'd3, 1'b1, p, lat);
    checks++; if (p !== 64'd15) $display("FAIL early_5x3_product got %h want f", p);
    else passes++;
    checks++; if (lat != exp5) $display("FAIL early_5x3_latency got %0d want %0d", lat, exp5);
    else passes++;
    release_out();
    do_op(32'hDEADBEEF, 32'd0, 1'b1, p, lat);
    checks++; if (p !== 64'd0) $display("FAIL early_bzero_product got %h want 0", p);
    else passes++;
    checks++; if (lat != exp0) $display("FAIL early_bzero_latency got %0d want %0d", lat, exp0);
    else passes++;
    release_out();
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    logic        s;
    logic [63:0] p, exp;
    int          lat;
    for (int i = 0; i < 2000; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom_range(0, 1));
      // Bias toward narrow multipliers so early exit sees a spread of latencies.
      case ($urandom_range(0, 3))
        0: y = y >> $urandom_range(0, 31);
        1: y = 32'($signed(y) >>> $urandom_range(0, 31));
        default: ;
      endcase
      exp = ref_prod(x, y, s);
      do_op(x, y, s, p, lat);
      checks++;
      if (p !== exp) $display("FAIL random_%0d_product a=%h b=%h s=%b got %h want %h",
                              i, x, y, s, p, exp);
      else passes++;
      checks++;
      if (lat != ref_lat(y, s)) $display("FAIL random_%0d_latency b=%h s=%b got %0d want %0d",
                                         i, y, s, lat, ref_lat(y, s));
      else passes++;
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_early_term();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
